rojobot_drive_ctrl: RTL and testbench
=====================================

# rojobot_drive_ctrl

Closed-loop drive controller for the Rojobot wheel model. It accepts a target position pair for the left and right 8-bit wheel counters through a valid/ready handshake. It drives the bot's `left_fwd`/`left_rev`/`right_fwd`/`right_rev` pushbutton inputs until the bot's reported `left_pos`/`right_pos` match the targets, then reports completion status. The block sits between pushbutton/command logic and the Rojobot instance, replacing direct button drive, and runs on the same clock as the bot.

## Interface
- `SIMULATE`, default 0: selects the stall limit. 0 gives `STALL_LIMIT` = 26'd39_999_999 (400 ms at 100 MHz, two bot ticks). 1 gives `STALL_LIMIT` = 26'd19.
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `cmd_valid` in 1: a target pair is presented.
- `cmd_ready` out 1: the block can accept a command (high only in IDLE).
- `cmd_left_tgt` in 8: left wheel target position.
- `cmd_right_tgt` in 8: right wheel target position.
- `abort` in 1: terminates the active move.
- `left_pos` in 8: bot left wheel position, same clock domain, used unregistered.
- `right_pos` in 8: bot right wheel position.
- `left_fwd`, `left_rev`, `right_fwd`, `right_rev` out 1 each: registered drive commands to the bot.
- `busy` out 1: high in MOVE.
- `done` out 1: one-cycle completion pulse.
- `status` out 2: meaningful only while `done` is high. 00 = arrived, 01 = stalled, 10 = aborted.

## Operation
- States: IDLE, MOVE, DONE.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid` the targets are latched and the state goes to MOVE.
  - `abort` is ignored in IDLE.
- **MOVE**
  - Each wheel independently computes `d = tgt - pos` mod 256 (8-bit wrap subtraction).
  - d == 0: no drive. d in 1..127: fwd=1. d in 128..255: rev=1. d == 128 resolves to rev.
  - fwd and rev of the same wheel are never high together.
  - Drives are recomputed every cycle from the live position, so wrap through 255↔0 takes the short path.
- **Exit from MOVE to DONE**
  - Arrived: both d == 0.
  - Abort: `abort`=1.
  - Stall: stall counter == `STALL_LIMIT`.
  - Priority in the same cycle: arrived > abort > stall.
- **DONE**
  - All drives are 0, `done`=1 and `status` is valid.
  - The state goes unconditionally to IDLE on the next edge.
- **Stall counter (26-bit)**
  - Cleared on command accept and whenever `left_pos` or `right_pos` differs from its registered previous-cycle value.
  - Otherwise increments in MOVE and saturates at `STALL_LIMIT`.
- `cmd_valid` outside IDLE is ignored; there is no queueing, and the command must be re-presented.

## Timing
- Reset values:
  - State IDLE, `cmd_ready`=1.
  - `busy`=0, `done`=0, `status`=00.
  - All four drives 0, stall counter 0.
- Reset asserted mid-move clears the drives asynchronously. No `done` pulse is issued for the interrupted move.
- Accept at edge T, when `cmd_valid && cmd_ready`:
  - MOVE, `busy`=1 and `cmd_ready`=0 are visible after T.
  - Drives are computed at T from `cmd_*_tgt` and the current positions, so they are valid in the cycle after T.
- Position change to drive update: one cycle.
  - The bot steps at most once per ≥6 cycles, so no overshoot occurs.
  - The position never steps past the target.
- Arrival seen at edge E: drives are 0 and `done`=1 for exactly cycle E+1, then `cmd_ready`=1 from E+2.
- A target equal to the current position gives `done` with status 00 two cycles after accept, with no drive asserted.
- Abort seen at edge A: drives drop and `done` is high in cycle A+1.
- Stall: `done` with status 01 after `STALL_LIMIT` consecutive cycles with no position change.
- Back-to-back commands:
  - Minimum spacing between accepts is 3 cycles (accept, ≥1 MOVE, DONE).
  - `cmd_valid` held high is accepted in the first IDLE cycle.

## Test plan
Bench: `RojoBot1` instantiated with `simulate=1` and this block with `SIMULATE=1`.
- Start from reset (positions 0), command L=5, R=0:
  - Only `left_fwd` asserts.
  - `left_pos` reaches 5 and stays 5.
  - `right_*` are never asserted.
  - `done`=1 for one cycle with `status`=00.
  - `cmd_ready` rises 2 cycles after arrival.
- Wrap:
  - From L=250, command L=4: `left_fwd` only, and `left_pos` steps 250..255, 0..4.
  - Then command L=250: `left_rev` only.
- Half-circle: from 0, command L=128 and R=127. Required: left uses rev for 128 steps, right uses fwd for 127 steps, and both arrive with `status`=00.
- Stall: force `left_pos` constant at 3 with target 9. Required: `done` with `status`=01 exactly 20 cycles after the last position change, drives 0 in the done cycle.
- Abort and reset:
  - `abort` pulsed mid-move: drives 0 the next cycle, `done` with `status`=10, and the position frozen.
  - Repeat with `reset_n` low mid-move: drives 0 immediately, no `done`, `cmd_ready`=1.
- Handshake:
  - A new `cmd_valid` during MOVE is ignored and the targets are unchanged.
  - A command equal to the current position gives `done`/00 two cycles after accept.
  - `cmd_valid` held high is re-accepted in the first IDLE cycle.

Source files
------------

// File: rtl/rojobot_drive_ctrl.sv
// Closed-loop wheel position controller for the Rojobot: accepts a left/right
// target pair and steps the bot's drive buttons until both wheel counters match.
module rojobot_drive_ctrl #(
  parameter int SIMULATE = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_left_tgt,
  input  logic [7:0] cmd_right_tgt,
  input  logic       abort,
  input  logic [7:0] left_pos,
  input  logic [7:0] right_pos,
  output logic       left_fwd,
  output logic       left_rev,
  output logic       right_fwd,
  output logic       right_rev,
  output logic       busy,
  output logic       done,
  output logic [1:0] status
);

  // state  | meaning
  // S_IDLE | waiting for a command, cmd_ready high
  // S_MOVE | driving wheels toward the latched targets
  // S_DONE | one-cycle completion pulse, status valid

  localparam logic [25:0] STALL_LIMIT = (SIMULATE != 0) ? 26'd19 : 26'd39_999_999;

  localparam logic [1:0] ST_ARRIVED = 2'b00;
  localparam logic [1:0] ST_STALLED = 2'b01;
  localparam logic [1:0] ST_ABORTED = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  left_tgt, right_tgt;
  logic [7:0]  left_prev, right_prev;
  logic [25:0] stall_cnt;
  logic [3:0]  drv, drv_nxt;
  logic [1:0]  status_nxt;
  logic        accept, arrived, stalled, moved;
  logic [7:0]  left_goal, right_goal;
  logic [1:0]  left_drv, right_drv;

  // Returns {fwd, rev}; the half-circle distance (128) resolves to reverse.
  function automatic logic [1:0] wheel_drive(input logic [7:0] tgt, input logic [7:0] pos);
    logic [7:0] d;
    d = tgt - pos;
    if (d == 8'd0)
      return 2'b00;
    else if (d[7])
      return 2'b01;
    else
      return 2'b10;
  endfunction

  assign accept     = (state == S_IDLE) && cmd_valid;
  assign left_goal  = accept ? cmd_left_tgt  : left_tgt;
  assign right_goal = accept ? cmd_right_tgt : right_tgt;
  assign left_drv   = wheel_drive(left_goal, left_pos);
  assign right_drv  = wheel_drive(right_goal, right_pos);
  assign arrived    = (left_pos == left_tgt) && (right_pos == right_tgt);
  assign stalled    = (stall_cnt == STALL_LIMIT);
  assign moved      = (left_pos != left_prev) || (right_pos != right_prev);

  always_comb begin
    state_nxt  = state;
    drv_nxt    = 4'b0000;
    status_nxt = status;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt = S_MOVE;
          drv_nxt   = {left_drv, right_drv};
        end
      end
      S_MOVE: begin
        if (arrived) begin
          state_nxt  = S_DONE;
          status_nxt = ST_ARRIVED;
        end else if (abort) begin
          state_nxt  = S_DONE;
          status_nxt = ST_ABORTED;
        end else if (stalled) begin
          state_nxt  = S_DONE;
          status_nxt = ST_STALLED;
        end else begin
          drv_nxt = {left_drv, right_drv};
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      drv        <= 4'b0000;
      status     <= ST_ARRIVED;
      left_tgt   <= 8'd0;
      right_tgt  <= 8'd0;
      left_prev  <= 8'd0;
      right_prev <= 8'd0;
      stall_cnt  <= 26'd0;
    end else begin
      state      <= state_nxt;
      drv        <= drv_nxt;
      status     <= status_nxt;
      left_prev  <= left_pos;
      right_prev <= right_pos;
      if (accept) begin
        left_tgt  <= cmd_left_tgt;
        right_tgt <= cmd_right_tgt;
      end
      // Any wheel movement restarts the stall window.
      if (accept || moved)
        stall_cnt <= 26'd0;
      else if (state == S_MOVE && !stalled)
        stall_cnt <= stall_cnt + 26'd1;
    end
  end

  assign {left_fwd, left_rev, right_fwd, right_rev} = drv;
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state == S_MOVE);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_rojobot_drive_ctrl.sv
// Directed bench for rojobot_drive_ctrl with a small behavioural wheel model
// that steps each position once every six clocks while its drive is held.
module tb_rojobot_drive_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_left_tgt = 8'd0;
  logic [7:0] cmd_right_tgt = 8'd0;
  logic       abort = 1'b0;
  logic [7:0] lpos = 8'd0;
  logic [7:0] rpos = 8'd0;
  logic       cmd_ready, left_fwd, left_rev, right_fwd, right_rev, busy, done;
  logic [1:0] status;

  logic       ld_en = 1'b0;
  logic [7:0] ld_l = 8'd0;
  logic [7:0] ld_r = 8'd0;
  logic       freeze_l = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int tick = 0;
  int lf_steps = 0, lr_steps = 0, rf_steps = 0, rr_steps = 0;
  int lstep_cyc = 0;
  int rdrv_cyc = 0, ldrv_cyc = 0, lrev_cyc = 0, both_cyc = 0, done_cyc = 0;
  int acc_cnt = 0, acc_last = 0, acc_prev = 0;

  rojobot_drive_ctrl #(.SIMULATE(1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_left_tgt  (cmd_left_tgt),
    .cmd_right_tgt (cmd_right_tgt),
    .abort         (abort),
    .left_pos      (lpos),
    .right_pos     (rpos),
    .left_fwd      (left_fwd),
    .left_rev      (left_rev),
    .right_fwd     (right_fwd),
    .right_rev     (right_rev),
    .busy          (busy),
    .done          (done),
    .status        (status)
  );

  always #5 clk = ~clk;

  // Wheel model plus activity counters
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    tick <= (tick == 5) ? 0 : tick + 1;
    if (ld_en) begin
      lpos <= ld_l;
      rpos <= ld_r;
    end else if (tick == 5) begin
      if (left_fwd && !freeze_l) begin
        lpos <= lpos + 8'd1; lf_steps <= lf_steps + 1; lstep_cyc <= cyc + 1;
      end else if (left_rev && !freeze_l) begin
        lpos <= lpos - 8'd1; lr_steps <= lr_steps + 1; lstep_cyc <= cyc + 1;
      end
      if (right_fwd) begin
        rpos <= rpos + 8'd1; rf_steps <= rf_steps + 1;
      end else if (right_rev) begin
        rpos <= rpos - 8'd1; rr_steps <= rr_steps + 1;
      end
    end
    if (right_fwd || right_rev) rdrv_cyc <= rdrv_cyc + 1;
    if (left_fwd || left_rev) ldrv_cyc <= ldrv_cyc + 1;
    if (left_rev) lrev_cyc <= lrev_cyc + 1;
    if ((left_fwd && left_rev) || (right_fwd && right_rev)) both_cyc <= both_cyc + 1;
    if (done) done_cyc <= done_cyc + 1;
    if (cmd_valid && cmd_ready) begin
      acc_cnt  <= acc_cnt + 1;
      acc_prev <= acc_last;
      acc_last <= cyc + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_pos(input logic [7:0] l, input logic [7:0] r);
    @(negedge clk);
    ld_en = 1'b1; ld_l = l; ld_r = r;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] l, input logic [7:0] r, output int t_acc);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_left_tgt = l; cmd_right_tgt = r;
    @(negedge clk);
    cmd_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_done(input string tag, input int max, output int t_done);
    bit ok;
    ok = 1'b0;
    t_done = -1;
    for (int i = 0; i < max; i++) begin
      if (done) begin
        ok = 1'b1;
        t_done = cyc;
        break;
      end
      @(negedge clk);
    end
    check_eq(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, td, s0, s1, s2, s3, p, dc;

    repeat (3) @(negedge clk);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_status", status, 0);
    check_eq("rst_drives", {left_fwd, left_rev, right_fwd, right_rev}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Simple forward move L=5, R=0
    s0 = rdrv_cyc; s1 = lrev_cyc;
    send_cmd(8'd5, 8'd0, ta);
    check_eq("mv_lfwd", left_fwd, 1);
    check_eq("mv_lrev", left_rev, 0);
    check_eq("mv_busy", busy, 1);
    check_eq("mv_ready", cmd_ready, 0);
    wait_done("mv_done_seen", 200, td);
    check_eq("mv_status", status, 0);
    check_eq("mv_lpos", lpos, 5);
    check_eq("mv_arrive_lat", td - lstep_cyc, 1);
    check_eq("mv_done_drives", {left_fwd, left_rev, right_fwd, right_rev}, 0);
    check_eq("mv_done_ready", cmd_ready, 0);
    @(negedge clk);
    check_eq("mv_pulse_width", done, 0);
    check_eq("mv_ready_after", cmd_ready, 1);
    repeat (10) @(negedge clk);
    check_eq("mv_lpos_hold", lpos, 5);
    check_eq("mv_right_idle", rdrv_cyc - s0, 0);
    check_eq("mv_no_lrev", lrev_cyc - s1, 0);

    // Wrap 250 -> 4 forward, then back to 250 in reverse
    load_pos(8'd250, 8'd0);
    s0 = lf_steps; s1 = lr_steps;
    send_cmd(8'd4, 8'd0, ta);
    wait_done("wrap_done_seen", 300, td);
    check_eq("wrap_status", status, 0);
    check_eq("wrap_lpos", lpos, 4);
    check_eq("wrap_fwd_steps", lf_steps - s0, 10);
    check_eq("wrap_rev_steps", lr_steps - s1, 0);
    s0 = lf_steps; s1 = lr_steps;
    send_cmd(8'd250, 8'd0, ta);
    check_eq("wrapb_lrev", left_rev, 1);
    wait_done("wrapb_done_seen", 300, td);
    check_eq("wrapb_lpos", lpos, 250);
    check_eq("wrapb_fwd_steps", lf_steps - s0, 0);
    check_eq("wrapb_rev_steps", lr_steps - s1, 10);

    // Half circle: 128 resolves to reverse, 127 forward
    load_pos(8'd0, 8'd0);
    s0 = lf_steps; s1 = lr_steps; s2 = rf_steps; s3 = rr_steps;
    send_cmd(8'd128, 8'd127, ta);
    wait_done("half_done_seen", 2000, td);
    check_eq("half_status", status, 0);
    check_eq("half_lpos", lpos, 128);
    check_eq("half_rpos", rpos, 127);
    check_eq("half_lrev_steps", lr_steps - s1, 128);
    check_eq("half_lfwd_steps", lf_steps - s0, 0);
    check_eq("half_rfwd_steps", rf_steps - s2, 127);
    check_eq("half_rrev_steps", rr_steps - s3, 0);

    // Stall: left wheel held at 3 while targeting 9
    load_pos(8'd3, 8'd127);
    freeze_l = 1'b1;
    send_cmd(8'd9, 8'd127, ta);
    check_eq("stall_lfwd", left_fwd, 1);
    wait_done("stall_done_seen", 100, td);
    check_eq("stall_latency", td - ta, 20);
    check_eq("stall_status", status, 1);
    check_eq("stall_drives", {left_fwd, left_rev, right_fwd, right_rev}, 0);
    check_eq("stall_lpos", lpos, 3);
    freeze_l = 1'b0;

    // Abort mid-move
    load_pos(8'd0, 8'd127);
    send_cmd(8'd50, 8'd127, ta);
    repeat (20) @(negedge clk);
    check_eq("abort_pre_lfwd", left_fwd, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_drives", {left_fwd, left_rev, right_fwd, right_rev}, 0);
    check_eq("abort_done", done, 1);
    check_eq("abort_status", status, 2);
    p = lpos;
    repeat (20) @(negedge clk);
    check_eq("abort_frozen", lpos, p);

    // Reset asserted mid-move
    send_cmd(8'd60, 8'd127, ta);
    repeat (10) @(negedge clk);
    check_eq("rstmv_pre_lfwd", left_fwd, 1);
    dc = done_cyc;
    reset_n = 1'b0;
    #1;
    check_eq("rstmv_drives", {left_fwd, left_rev, right_fwd, right_rev}, 0);
    check_eq("rstmv_ready", cmd_ready, 1);
    check_eq("rstmv_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rstmv_no_done", done_cyc - dc, 0);

    // New command during MOVE is ignored
    load_pos(8'd100, 8'd127);
    send_cmd(8'd110, 8'd127, ta);
    cmd_valid = 1'b1; cmd_left_tgt = 8'd200; cmd_right_tgt = 8'd5;
    repeat (3) @(negedge clk);
    check_eq("hs_ready_move", cmd_ready, 0);
    cmd_valid = 1'b0;
    wait_done("hs_done_seen", 300, td);
    check_eq("hs_lpos", lpos, 110);
    check_eq("hs_rpos", rpos, 127);
    check_eq("hs_status", status, 0);

    // Target equal to current position
    s0 = ldrv_cyc; s1 = rdrv_cyc;
    send_cmd(8'd110, 8'd127, ta);
    check_eq("eq_no_early_done", done, 0);
    @(negedge clk);
    check_eq("eq_done", done, 1);
    check_eq("eq_status", status, 0);
    check_eq("eq_no_drive", (ldrv_cyc - s0) + (rdrv_cyc - s1), 0);

    // cmd_valid held high is re-accepted in the first IDLE cycle
    @(negedge clk);
    s0 = acc_cnt;
    cmd_valid = 1'b1; cmd_left_tgt = 8'd110; cmd_right_tgt = 8'd127;
    for (int i = 0; i < 20; i++) begin
      if (acc_cnt - s0 >= 2) break;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check_eq("held_accepts", (acc_cnt - s0 >= 2) ? 1 : 0, 1);
    check_eq("held_spacing", acc_last - acc_prev, 3);
    repeat (4) @(negedge clk);
    check_eq("never_both_dirs", both_cyc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
